// File: rtl/framebuffer_dbuf_if.sv
// Renderer / output-module bus of the double-buffered framebuffer.
// Coordinate fields carry one spare bit so off-screen positions stay representable.
interface framebuffer_dbuf_if #(
  parameter int unsigned WIDTH      = 320,
  parameter int unsigned HEIGHT     = 240,
  parameter int unsigned COLOR_BITS = 3
);
  localparam int unsigned XW = $clog2(WIDTH) + 1;
  localparam int unsigned YW = $clog2(HEIGHT) + 1;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } screen_xy_t;

  logic                  new_frame;
  screen_xy_t            output_module_coords;
  logic [COLOR_BITS-1:0] color_out;
  logic                  wr_valid;
  logic                  wr_ready;
  screen_xy_t            wr_coords;
  logic [COLOR_BITS-1:0] wr_color;
  logic                  swap_req;
  logic                  swap_pending;
  logic                  front_sel;
  logic                  clear_req;
  logic [COLOR_BITS-1:0] clear_color;
  logic                  busy;
  logic [7:0]            frame_count;

  modport master (
    output new_frame, output_module_coords, wr_valid, wr_coords, wr_color,
    output swap_req, clear_req, clear_color,
    input  color_out, wr_ready, swap_pending, front_sel, busy, frame_count
  );

  modport slave (
    input  new_frame, output_module_coords, wr_valid, wr_coords, wr_color,
    input  swap_req, clear_req, clear_color,
    output color_out, wr_ready, swap_pending, front_sel, busy, frame_count
  );
endinterface

// File: rtl/framebuffer_dbuf.sv
// Double-buffered framebuffer: renderer writes the back bank, display reads the front bank,
// swaps land on new_frame. Define FB_CLEAR_EN to build the back-bank clear engine.
module framebuffer_dbuf #(
  parameter int unsigned WIDTH      = 320,
  parameter int unsigned HEIGHT     = 240,
  parameter int unsigned COLOR_BITS = 3
) (
  input logic               Clk,
  input logic               Reset,
  framebuffer_dbuf_if.slave fb
);
  localparam int unsigned DEPTH = WIDTH * HEIGHT;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned XW    = $clog2(WIDTH) + 1;
  localparam int unsigned YW    = $clog2(HEIGHT) + 1;

  logic [COLOR_BITS-1:0] mem [2][DEPTH];

  logic                  front_sel_q;
  logic                  swap_pending_q;
  logic [7:0]            frame_count_q;
  logic [COLOR_BITS-1:0] color_q;
  logic                  back_sel;
  logic                  idle;
  logic                  swap_fire;

`ifdef FB_CLEAR_EN
  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                state_q;
  logic                  busy_q;
  logic [AW-1:0]         clr_addr_q;
  logic [COLOR_BITS-1:0] clr_color_q;

  assign idle    = (state_q == StIdle);
  assign fb.busy = busy_q;
`else
  assign idle    = 1'b1;
  assign fb.busy = 1'b0;
`endif

  // Read side
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic          rd_in_range;
  logic [AW-1:0] rd_addr;

  assign rd_x        = fb.output_module_coords.x;
  assign rd_y        = fb.output_module_coords.y;
  assign rd_in_range = (rd_x < XW'(WIDTH)) && (rd_y < YW'(HEIGHT));
  assign rd_addr     = AW'(32'(rd_y) * WIDTH + 32'(rd_x));

  // Write side
  logic [XW-1:0]         wr_x;
  logic [YW-1:0]         wr_y;
  logic                  wr_in_range;
  logic [AW-1:0]         wr_addr;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [COLOR_BITS-1:0] mem_wdata;

  assign wr_x        = fb.wr_coords.x;
  assign wr_y        = fb.wr_coords.y;
  assign wr_in_range = (wr_x < XW'(WIDTH)) && (wr_y < YW'(HEIGHT));
  assign wr_addr     = AW'(32'(wr_y) * WIDTH + 32'(wr_x));

  assign back_sel    = ~front_sel_q;
  assign fb.wr_ready = Reset && idle && !swap_pending_q;
  assign swap_fire   = fb.new_frame && swap_pending_q && idle;

  // Out-of-range writes still complete the handshake but never reach the array.
  always_comb begin
    mem_we    = fb.wr_valid && fb.wr_ready && wr_in_range;
    mem_waddr = wr_addr;
    mem_wdata = fb.wr_color;
`ifdef FB_CLEAR_EN
    if (state_q == StClear) begin
      mem_we    = Reset;
      mem_waddr = clr_addr_q;
      mem_wdata = clr_color_q;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[back_sel][mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      color_q <= '0;
    end else if (rd_in_range) begin
      color_q <= mem[front_sel_q][rd_addr];
    end else begin
      color_q <= '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      frame_count_q  <= 8'd0;
`ifdef FB_CLEAR_EN
      state_q        <= StIdle;
      busy_q         <= 1'b0;
      clr_addr_q     <= '0;
      clr_color_q    <= '0;
`endif
    end else begin
      if (fb.new_frame) begin
        frame_count_q <= frame_count_q + 8'd1;
      end
      // A swap consumes the pending flag, so a swap_req on that same cycle is absorbed.
      if (swap_fire) begin
        front_sel_q    <= ~front_sel_q;
        swap_pending_q <= 1'b0;
      end else if (fb.swap_req) begin
        swap_pending_q <= 1'b1;
      end
`ifdef FB_CLEAR_EN
      unique case (state_q)
        StIdle: begin
          if (fb.clear_req && !swap_pending_q) begin
            state_q     <= StClear;
            busy_q      <= 1'b1;
            clr_addr_q  <= '0;
            clr_color_q <= fb.clear_color;
          end
        end
        StClear: begin
          if (clr_addr_q == AW'(DEPTH - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + AW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
`endif
    end
  end

  assign fb.color_out    = color_q;
  assign fb.front_sel    = front_sel_q;
  assign fb.swap_pending = swap_pending_q;
  assign fb.frame_count  = frame_count_q;

endmodule

// File: tb/tb_framebuffer_dbuf.sv
// Directed bench for framebuffer_dbuf: writes, out-of-range accesses, swap timing,
// frame counter wrap, reset, and the clear engine when FB_CLEAR_EN is defined.
module tb_framebuffer_dbuf;
  localparam int unsigned W     = 320;
  localparam int unsigned H     = 240;
  localparam int unsigned C     = 3;
  localparam int unsigned XW    = $clog2(W) + 1;
  localparam int unsigned YW    = $clog2(H) + 1;
  localparam int unsigned DEPTH = W * H;

  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_errors;

  framebuffer_dbuf_if #(.WIDTH(W), .HEIGHT(H), .COLOR_BITS(C)) fb_if ();

  framebuffer_dbuf #(.WIDTH(W), .HEIGHT(H), .COLOR_BITS(C)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .fb    (fb_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_px(input int x, input int y, input int c);
    fb_if.wr_valid    = 1'b1;
    fb_if.wr_coords.x = XW'(x);
    fb_if.wr_coords.y = YW'(y);
    fb_if.wr_color    = C'(c);
    check("wr_ready_on_write", 32'(fb_if.wr_ready), 1);
    tick();
    fb_if.wr_valid = 1'b0;
  endtask

  task automatic read_px(input string tag, input int x, input int y, input int exp);
    fb_if.output_module_coords.x = XW'(x);
    fb_if.output_module_coords.y = YW'(y);
    tick();
    check(tag, 32'(fb_if.color_out), 32'(exp));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    Reset                  = 1'b0;
    fb_if.new_frame        = 1'b0;
    fb_if.output_module_coords = '0;
    fb_if.wr_valid         = 1'b0;
    fb_if.wr_coords        = '0;
    fb_if.wr_color         = '0;
    fb_if.swap_req         = 1'b0;
    fb_if.clear_req        = 1'b0;
    fb_if.clear_color      = '0;

    // Reset state
    tick();
    tick();
    check("rst_color_out", 32'(fb_if.color_out), 0);
    check("rst_front_sel", 32'(fb_if.front_sel), 0);
    check("rst_swap_pending", 32'(fb_if.swap_pending), 0);
    check("rst_busy", 32'(fb_if.busy), 0);
    check("rst_frame_count", 32'(fb_if.frame_count), 0);
    check("rst_wr_ready_low", 32'(fb_if.wr_ready), 0);
    Reset = 1'b1;
    tick();
    check("wr_ready_after_rst", 32'(fb_if.wr_ready), 1);

    // Fill back bank (bank 1); the (400,5) write would alias pixel (80,6)
    write_px(10, 20, 5);
    write_px(319, 239, 7);
    write_px(80, 6, 2);
    write_px(0, 1, 4);
    write_px(400, 5, 6);

    fb_if.swap_req = 1'b1;
    tick();
    fb_if.swap_req = 1'b0;
    check("pending_set", 32'(fb_if.swap_pending), 1);
    check("front_before_swap", 32'(fb_if.front_sel), 0);
    fb_if.new_frame = 1'b1;
    tick();
    fb_if.new_frame = 1'b0;
    check("front_after_swap1", 32'(fb_if.front_sel), 1);
    check("pending_clr_swap1", 32'(fb_if.swap_pending), 0);
    check("frame_count_1", 32'(fb_if.frame_count), 1);

    read_px("rd_10_20", 10, 20, 5);
    read_px("rd_319_239", 319, 239, 7);
    read_px("rd_80_6_no_alias", 80, 6, 2);
    read_px("rd_0_1", 0, 1, 4);
    read_px("rd_x_oob", 320, 0, 0);
    read_px("rd_y_oob", 0, 240, 0);

    // Pending swap with no new_frame blocks writes and leaves the display alone
    write_px(10, 20, 1);
    fb_if.swap_req = 1'b1;
    tick();
    fb_if.swap_req    = 1'b0;
    fb_if.wr_valid    = 1'b1;
    fb_if.wr_coords.x = XW'(10);
    fb_if.wr_coords.y = YW'(20);
    fb_if.wr_color    = C'(6);
    fb_if.output_module_coords.x = XW'(10);
    fb_if.output_module_coords.y = YW'(20);
    repeat (100) tick();
    check("pending_hold", 32'(fb_if.swap_pending), 1);
    check("wr_ready_blocked", 32'(fb_if.wr_ready), 0);
    check("front_hold", 32'(fb_if.front_sel), 1);
    check("display_hold", 32'(fb_if.color_out), 5);
    fb_if.wr_valid = 1'b0;

    fb_if.new_frame = 1'b1;
    tick();
    fb_if.new_frame = 1'b0;
    check("front_after_swap2", 32'(fb_if.front_sel), 0);
    check("frame_count_2", 32'(fb_if.frame_count), 2);
    read_px("rd_bank0_blocked_wr", 10, 20, 1);

    // swap_req together with new_frame: no swap until the next pulse
    fb_if.swap_req  = 1'b1;
    fb_if.new_frame = 1'b1;
    tick();
    fb_if.swap_req  = 1'b0;
    fb_if.new_frame = 1'b0;
    check("same_cycle_no_swap", 32'(fb_if.front_sel), 0);
    check("same_cycle_pending", 32'(fb_if.swap_pending), 1);
    check("frame_count_3", 32'(fb_if.frame_count), 3);
    fb_if.new_frame = 1'b1;
    tick();
    fb_if.new_frame = 1'b0;
    check("next_frame_swaps", 32'(fb_if.front_sel), 1);
    check("frame_count_4", 32'(fb_if.frame_count), 4);
    read_px("rd_bank1_again", 10, 20, 5);

    // Frame counter wrap
    fb_if.new_frame = 1'b1;
    repeat (251) tick();
    check("frame_count_255", 32'(fb_if.frame_count), 255);
    tick();
    fb_if.new_frame = 1'b0;
    check("frame_count_wrap", 32'(fb_if.frame_count), 0);
    check("front_after_wrap", 32'(fb_if.front_sel), 1);

`ifdef FB_CLEAR_EN
    begin
      int cnt;
      fb_if.clear_req   = 1'b1;
      fb_if.clear_color = C'(3);
      tick();
      fb_if.clear_req   = 1'b0;
      fb_if.clear_color = C'(0);
      check("clear_busy", 32'(fb_if.busy), 1);
      check("clear_wr_ready", 32'(fb_if.wr_ready), 0);
      cnt = 0;
      while (fb_if.busy === 1'b1 && cnt < 100000) begin
        fb_if.swap_req  = (cnt == 100);
        fb_if.new_frame = (cnt == 200);
        cnt++;
        tick();
      end
      fb_if.swap_req  = 1'b0;
      fb_if.new_frame = 1'b0;
      check("clear_cycles", 32'(cnt), DEPTH);
      check("clear_no_swap_mid", 32'(fb_if.front_sel), 1);
      check("clear_pending", 32'(fb_if.swap_pending), 1);
      fb_if.new_frame = 1'b1;
      tick();
      fb_if.new_frame = 1'b0;
      check("clear_swap_after", 32'(fb_if.front_sel), 0);
      read_px("clr_0_0", 0, 0, 3);
      read_px("clr_10_20", 10, 20, 3);
      read_px("clr_319_239", 319, 239, 3);

      fb_if.clear_req = 1'b1;
      tick();
      fb_if.clear_req = 1'b0;
      fb_if.swap_req  = 1'b1;
      tick();
      fb_if.swap_req  = 1'b0;
      repeat (50) tick();
      check("busy_before_rst", 32'(fb_if.busy), 1);
    end
`else
    fb_if.clear_req   = 1'b1;
    fb_if.clear_color = C'(3);
    tick();
    fb_if.clear_req = 1'b0;
    check("no_clear_busy", 32'(fb_if.busy), 0);
    check("no_clear_wr_ready", 32'(fb_if.wr_ready), 1);
    read_px("no_clear_pixel", 10, 20, 5);
    fb_if.swap_req = 1'b1;
    tick();
    fb_if.swap_req = 1'b0;
`endif

    // Reset in the middle of activity
    check("pending_before_rst", 32'(fb_if.swap_pending), 1);
    Reset = 1'b0;
    tick();
    check("mid_rst_busy", 32'(fb_if.busy), 0);
    check("mid_rst_front", 32'(fb_if.front_sel), 0);
    check("mid_rst_pending", 32'(fb_if.swap_pending), 0);
    check("mid_rst_wr_ready", 32'(fb_if.wr_ready), 0);
    check("mid_rst_color", 32'(fb_if.color_out), 0);
    Reset = 1'b1;
    tick();
    check("wr_ready_release", 32'(fb_if.wr_ready), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
